// File: rtl/sfb_pkg.sv
// Shared constants and state type for the SRAM frame-buffer read path.
package sfb_pkg;

  localparam int unsigned SFB_FRAME_PIXELS = 307200;
  localparam int unsigned SFB_ADDR_W       = 20;
  localparam int unsigned SFB_DATA_W       = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } sfb_state_e;

endpackage

// File: rtl/sfb_sync_fifo.sv
// Synchronous FIFO with flush; head word reads as zero while empty.
module sfb_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop, full;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/sram_frame_reader.sv
// Linear frame read from async SRAM into a credit-throttled prefetch FIFO.
// Optional underflow counter: define SRAM_READER_UNDERFLOW_CNT_EN.
module sram_frame_reader
  import sfb_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = SFB_FRAME_PIXELS,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ADDR_W       = SFB_ADDR_W,
  parameter int unsigned DATA_W       = SFB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              ce_n,
  output logic              ub_n,
  output logic              lb_n,
  output logic              we_n,
  output logic              oe_n,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic [15:0]       underflow_cnt
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CW + 1;

  sfb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              oe_n_q, oe_n_d;
  logic              inflight_q, inflight_d;
  logic              frame_done_q, frame_done_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              pop, credit, last_addr;
  logic [OCC_W-1:0]  occ;

  assign ce_n = 1'b0;
  assign ub_n = 1'b0;
  assign lb_n = 1'b0;
  assign we_n = 1'b1;

  assign sram_addr  = sram_addr_q;
  assign oe_n       = oe_n_q;
  assign frame_done = frame_done_q;
  assign pix_valid  = !fifo_empty;
  assign pop        = pix_valid && pix_ready;

  // Occupancy once this cycle settles: the in-flight word will land, the pop leaves.
  assign occ       = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign credit    = occ < OCC_W'(FIFO_DEPTH);
  assign last_addr = (addr_q == ADDR_W'(FRAME_PIXELS - 1));

  sfb_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (frame_start),
    .push_i  (inflight_q),
    .wdata_i (sram_dq_in),
    .pop_i   (pop),
    .head_o  (pix_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sram_addr_d  = sram_addr_q;
    oe_n_d       = 1'b1;
    inflight_d   = 1'b0;
    frame_done_d = 1'b0;
    if (frame_start) begin
      addr_d  = '0;
      state_d = READ;
    end else begin
      case (state_q)
        READ: begin
          if (credit) begin
            sram_addr_d = addr_q;
            oe_n_d      = 1'b0;
            inflight_d  = 1'b1;
            if (last_addr) state_d = DRAIN;
            else           addr_d  = addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (fifo_empty && !inflight_q) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      sram_addr_q  <= '0;
      oe_n_q       <= 1'b1;
      inflight_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sram_addr_q  <= sram_addr_d;
      oe_n_q       <= oe_n_d;
      inflight_q   <= inflight_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SRAM_READER_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      uf_cnt_q <= '0;
    end else if (pix_ready && !pix_valid && (state_q != IDLE) && (uf_cnt_q != '1)) begin
      uf_cnt_q <= uf_cnt_q + 1'b1;
    end
  end

  assign underflow_cnt = uf_cnt_q;
`else
  assign underflow_cnt = '0;
`endif

endmodule
